led_heartbeat_gen: RTL and testbench

LED_HEARTBEAT_GEN -- requirements
Module: led_heartbeat_gen

---
 rtl/led_heartbeat_gen.sv | 163 ++++++++++++++++
 tb/tb_led_heartbeat_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_heartbeat_gen.sv
// Purpose : frame-locked LED heartbeat pattern generator (binary / walking one / ping-pong / hold).
// Latency : step and pattern update one cycle after the qualifying next_frame rising edge; led follows pattern combinationally, or one cycle later with LED_PWM_EN.
// Backpr. : none; enable=0 freezes the pattern and frame counter, next_frame edge tracking keeps running.
//
// Ports:
//   hdmi_clk    - sole clock, rising edge
//   reset       - synchronous, active-high
//   next_frame  - frame marker; only its rising edge counts as a frame tick
//   enable      - 1 = pattern may advance, 0 = frozen
//   mode        - 00 binary, 01 walking one, 10 ping-pong, 11 hold
//   frame_div   - frames per pattern step (0 behaves as 1)
//   led         - pattern output
//   step        - one-cycle pulse on each pattern advance
//
// Build option: define LED_PWM_EN to dim the output with an 8-bit PWM
// (on while pwm counter < BRIGHTNESS); the BRIGHTNESS parameter only exists then.

module led_heartbeat_gen #(
    parameter int LED_W = 8,
    parameter int DIV_W = 8
`ifdef LED_PWM_EN
    ,
    parameter logic [7:0] BRIGHTNESS = 8'd64
`endif
) (
    input  logic             hdmi_clk,
    input  logic             reset,
    input  logic             next_frame,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] frame_div,
    output logic [LED_W-1:0] led,
    output logic             step
);

    typedef enum logic [1:0] {
        MODE_BIN  = 2'b00,
        MODE_WALK = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    // Registered state
    logic             nf_q;
    mode_e            mode_q;
    logic [DIV_W-1:0] frame_cnt;
    logic [LED_W-1:0] pattern;
    logic             dir_up;
    logic             step_q;

    // Next-state values
    logic [DIV_W-1:0] frame_cnt_nxt;
    logic [LED_W-1:0] pattern_nxt;
    logic             dir_up_nxt;
    logic             step_nxt;

    logic             tick;
    logic             mode_chg;
    logic [DIV_W-1:0] div_eff;
    mode_e            mode_in;

    assign mode_in  = mode_e'(mode);
    assign mode_chg = (mode_q != mode_in);
    // Edge detector always samples next_frame; enable only gates the tick so
    // re-enabling during a long-high marker does not produce a false frame.
    assign tick     = enable & next_frame & ~nf_q;
    assign div_eff  = (frame_div == '0) ? DIV_W'(1) : frame_div;

    always_comb begin
        frame_cnt_nxt = frame_cnt;
        pattern_nxt   = pattern;
        dir_up_nxt    = dir_up;
        step_nxt      = 1'b0;

        if (mode_chg) begin
            // Mode load wins over any step that would happen this cycle.
            frame_cnt_nxt = '0;
            case (mode_in)
                MODE_BIN:  pattern_nxt = '0;
                MODE_WALK: pattern_nxt = LED_W'(1);
                MODE_PING: begin
                    pattern_nxt = LED_W'(1);
                    dir_up_nxt  = 1'b1;
                end
                default:   pattern_nxt = pattern;
            endcase
        end else if (tick) begin
            // ">=" rather than "==" so a shrunken divisor wraps on the next tick.
            if (frame_cnt >= div_eff - DIV_W'(1)) begin
                frame_cnt_nxt = '0;
                step_nxt      = 1'b1;
                case (mode_q)
                    MODE_BIN:  pattern_nxt = pattern + LED_W'(1);
                    MODE_WALK: pattern_nxt = {pattern[LED_W-2:0], pattern[LED_W-1]};
                    MODE_PING: begin
                        // Reverse when the newly shown bit reaches an end, so
                        // each end is displayed exactly once.
                        if (dir_up) begin
                            if (pattern[LED_W-1]) begin
                                pattern_nxt = pattern >> 1;
                                dir_up_nxt  = 1'b0;
                            end else begin
                                pattern_nxt = pattern << 1;
                                dir_up_nxt  = ~pattern[LED_W-2];
                            end
                        end else begin
                            if (pattern[0]) begin
                                pattern_nxt = pattern << 1;
                                dir_up_nxt  = 1'b1;
                            end else begin
                                pattern_nxt = pattern >> 1;
                                dir_up_nxt  = pattern[1];
                            end
                        end
                    end
                    default: pattern_nxt = pattern;
                endcase
            end else begin
                frame_cnt_nxt = frame_cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge hdmi_clk) begin
        if (reset) begin
            nf_q      <= 1'b0;
            mode_q    <= MODE_BIN;
            frame_cnt <= '0;
            pattern   <= '0;
            dir_up    <= 1'b1;
            step_q    <= 1'b0;
        end else begin
            nf_q      <= next_frame;
            mode_q    <= mode_in;
            frame_cnt <= frame_cnt_nxt;
            pattern   <= pattern_nxt;
            dir_up    <= dir_up_nxt;
            step_q    <= step_nxt;
        end
    end

    assign step = step_q;

`ifdef LED_PWM_EN
    logic [7:0]       pwm_cnt;
    logic [LED_W-1:0] led_q;

    always_ff @(posedge hdmi_clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            led_q   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            led_q   <= pattern & {LED_W{pwm_cnt < BRIGHTNESS}};
        end
    end

    assign led = led_q;
`else
    assign led = pattern;
`endif

endmodule

// File: tb/tb_led_heartbeat_gen.sv
// Purpose : directed self-checking bench for led_heartbeat_gen (LED_W=8, DIV_W=8).
// Latency : inputs driven 1ns after the rising edge, outputs sampled 1ns after the edge or on the falling edge.
// Backpr. : none; every phase runs a fixed number of cycles.

module tb_led_heartbeat_gen;

    logic       hdmi_clk = 1'b0;
    logic       reset;
    logic       next_frame;
    logic       enable;
    logic [1:0] mode;
    logic [7:0] frame_div;
    logic [7:0] led;
    logic       step;

    int total = 0;
    int bad   = 0;
    int step_cnt = 0;
    int base;

    led_heartbeat_gen #(.LED_W(8), .DIV_W(8)) dut (
        .hdmi_clk   (hdmi_clk),
        .reset      (reset),
        .next_frame (next_frame),
        .enable     (enable),
        .mode       (mode),
        .frame_div  (frame_div),
        .led        (led),
        .step       (step)
    );

    always #5 hdmi_clk = ~hdmi_clk;

    always @(negedge hdmi_clk) if (step === 1'b1) step_cnt <= step_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge hdmi_clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        next_frame = 1'b1;
        cyc(hi);
        next_frame = 1'b0;
        cyc(lo);
    endtask

    logic [7:0] pp_exp [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

    initial begin
        reset      = 1'b1;
        next_frame = 1'b0;
        enable     = 1'b1;
        mode       = 2'b00;
        frame_div  = 8'd60;
        cyc(2);
        @(negedge hdmi_clk);
        check_eq("rst_led", led, 8'h00);
        check_eq("rst_step", step, 1'b0);
        check_eq("rst_cnt", dut.frame_cnt, 8'd0);
        reset = 1'b0;
        cyc(1);

`ifdef LED_PWM_EN
        begin
            int on_cnt;
            int off_cnt;
            frame_div = 8'd1;
            repeat (255) pulse(1, 1);
            mode = 2'b11;
            cyc(2);
            on_cnt  = 0;
            off_cnt = 0;
            for (int i = 0; i < 256; i++) begin
                @(negedge hdmi_clk);
                if (led == 8'hFF) on_cnt++;
                if (led == 8'h00) off_cnt++;
            end
            check_eq("pwm_on", on_cnt, 64);
            check_eq("pwm_off", off_cnt, 192);
        end
`else
        // Binary, divide by 60, 3-cycle-wide markers
        base = step_cnt;
        repeat (120) pulse(3, 2);
        check_eq("bin60_steps", step_cnt - base, 2);
        check_eq("bin60_led", led, 8'h02);
        check_eq("bin60_cnt", dut.frame_cnt, 8'd0);

        // Ping-pong, one step per frame
        mode = 2'b10;
        frame_div = 8'd1;
        cyc(1);
        check_eq("pp_load", led, 8'h01);
        for (int i = 0; i < 16; i++) begin
            pulse(1, 1);
            check_eq($sformatf("pp_%0d", i), led, pp_exp[i]);
        end

        // Walking one, frame_div=0 acts as 1; step timing and width
        mode = 2'b01;
        frame_div = 8'd0;
        cyc(1);
        check_eq("walk_load", led, 8'h01);
        next_frame = 1'b1;
        @(negedge hdmi_clk);
        check_eq("walk_step_early", step, 1'b0);
        cyc(1);
        check_eq("walk_step_on", step, 1'b1);
        check_eq("walk_led1", led, 8'h02);
        next_frame = 1'b0;
        cyc(1);
        check_eq("walk_step_off", step, 1'b0);
        repeat (6) pulse(1, 1);
        check_eq("walk_msb", led, 8'h80);
        pulse(1, 1);
        check_eq("walk_wrap", led, 8'h01);

        // Binary to 0xFE, enable gating, wrap, mode change during a step
        mode = 2'b00;
        frame_div = 8'd1;
        cyc(1);
        check_eq("bin_load", led, 8'h00);
        repeat (254) pulse(1, 1);
        check_eq("bin_fe", led, 8'hFE);
        base = step_cnt;
        enable = 1'b0;
        repeat (2) pulse(1, 1);
        next_frame = 1'b1;
        cyc(2);
        enable = 1'b1;
        cyc(2);
        check_eq("en_led", led, 8'hFE);
        check_eq("en_steps", step_cnt - base, 0);
        next_frame = 1'b0;
        cyc(1);
        pulse(1, 1);
        check_eq("bin_ff", led, 8'hFF);
        pulse(1, 1);
        check_eq("bin_wrap", led, 8'h00);
        repeat (255) pulse(1, 1);
        check_eq("bin_ff2", led, 8'hFF);
        next_frame = 1'b1;
        mode = 2'b01;
        cyc(1);
        check_eq("chg_led", led, 8'h01);
        check_eq("chg_step", step, 1'b0);
        check_eq("chg_cnt", dut.frame_cnt, 8'd0);
        next_frame = 1'b0;
        cyc(1);

        // Hold mode keeps pattern, still steps
        mode = 2'b11;
        cyc(1);
        check_eq("hold_load", led, 8'h01);
        base = step_cnt;
        repeat (3) pulse(1, 1);
        check_eq("hold_led", led, 8'h01);
        check_eq("hold_steps", step_cnt - base, 3);

        // Divisor shrinks below the current count
        mode = 2'b00;
        frame_div = 8'd10;
        cyc(1);
        check_eq("div_load", led, 8'h00);
        repeat (7) pulse(1, 1);
        check_eq("div_cnt7", dut.frame_cnt, 8'd7);
        check_eq("div_led0", led, 8'h00);
        frame_div = 8'd3;
        base = step_cnt;
        pulse(1, 1);
        check_eq("div_wrap_cnt", dut.frame_cnt, 8'd0);
        check_eq("div_wrap_led", led, 8'h01);
        check_eq("div_wrap_steps", step_cnt - base, 1);
        repeat (3) pulse(1, 1);
        check_eq("div3_led", led, 8'h02);
        check_eq("div3_steps", step_cnt - base, 2);

        // Reset mid-count, then reset during a step and a pending mode load
        frame_div = 8'd60;
        repeat (217) pulse(1, 1);
        check_eq("mid_led", led, 8'h05);
        check_eq("mid_cnt", dut.frame_cnt, 8'd37);
        reset = 1'b1;
        cyc(1);
        check_eq("mid_rst_led", led, 8'h00);
        check_eq("mid_rst_cnt", dut.frame_cnt, 8'd0);
        check_eq("mid_rst_step", step, 1'b0);
        reset = 1'b0;
        cyc(1);
        check_eq("post_rst_bin", led, 8'h00);
        mode = 2'b01;
        cyc(1);
        check_eq("walk_load2", led, 8'h01);
        frame_div = 8'd0;
        next_frame = 1'b1;
        reset = 1'b1;
        cyc(1);
        check_eq("rst_step_led", led, 8'h00);
        check_eq("rst_step_step", step, 1'b0);
        reset = 1'b0;
        next_frame = 1'b0;
        cyc(1);
        check_eq("post_rst_walk", led, 8'h01);
        check_eq("post_rst_step", step, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
